// File: rtl/aru_seq_if.sv
// -----------------------------------------------------------------------------
// aru_seq_if -- request/result bundle for the aru_seq arithmetic unit.
//
// Signals (names follow the unit's port list):
//   start      request strobe, accepted only while busy=0
//   op[1:0]    00 ADD, 01 SUB, 10 MUL, 11 NOP
//   in0, in1   WIDTH-bit operands (two's complement)
//   busy       MUL iteration in progress
//   done       one-cycle completion pulse
//   res        registered result
//   Z/N/C/V    registered zero/negative/carry/overflow flags
//
// Modports: master = controller side (drives request), slave = aru_seq.
// -----------------------------------------------------------------------------
interface aru_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;

    modport master (
        output start, op, in0, in1,
        input  busy, done, res, Z, N, C, V
    );

    modport slave (
        input  start, op, in0, in1,
        output busy, done, res, Z, N, C, V
    );
endinterface

// File: rtl/aru_seq.sv
// -----------------------------------------------------------------------------
// aru_seq -- registered arithmetic unit: ADD, SUB, NOP in one cycle, unsigned
// MUL_W x MUL_W multiply-low by iterative shift-add over MUL_W cycles.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   bus     aru_seq_if.slave: start/op/in0/in1 in; busy/done/res/Z/N/C/V out
//
// Parameters:
//   WIDTH   operand/result width (>= 4)
//   MUL_W   multiplier operand width, 2*MUL_W <= WIDTH; the product of
//           in0[MUL_W-1:0] and in1[MUL_W-1:0] is zero-extended into res.
// -----------------------------------------------------------------------------
module aru_seq #(
    parameter int WIDTH = 16,
    parameter int MUL_W = WIDTH / 2
) (
    input  logic        clk,
    input  logic        rst_n,
    aru_seq_if.slave    bus
);

    localparam int PW = 2 * MUL_W;           // full product width
    localparam int CW = $clog2(MUL_W + 1);   // iteration counter width

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_NOP = 2'b11
    } op_t;

    // ---------------- state and datapath registers ----------------
    state_t           r_state;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [MUL_W-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_z, r_n, r_c, r_v;
    logic             r_done;

    // ---------------- next-state values ----------------
    state_t           w_state_nxt;
    logic [PW-1:0]    w_acc_nxt;
    logic [PW-1:0]    w_mcand_nxt;
    logic [MUL_W-1:0] w_mplier_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_z_nxt, w_n_nxt, w_c_nxt, w_v_nxt;
    logic             w_done_nxt;

    // ---------------- combinational datapath ----------------
    op_t              w_op;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [PW-1:0]    w_acc_step;
    logic             w_last;

    assign w_op     = op_t'(bus.op);
    assign w_is_sub = (w_op == OP_SUB);

    // SUB is ADD of the inverted operand with carry-in 1, so the carry out
    // reads as "no borrow" and one adder serves both ops.
    assign w_b_eff = w_is_sub ? ~bus.in1 : bus.in1;
    assign w_sum   = {1'b0, bus.in0} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};

    // Overflow against the effective addend covers both cases: for SUB,
    // sign(a) != sign(b) is the same as sign(a) == sign(~b).
    assign w_ovf = (bus.in0[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.in0[WIDTH-1]);

    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : {PW{1'b0}});
    assign w_last     = (r_cnt == CW'(MUL_W - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= w_cnt_nxt;
            r_res    <= w_res_nxt;
            r_z      <= w_z_nxt;
            r_n      <= w_n_nxt;
            r_c      <= w_c_nxt;
            r_v      <= w_v_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // ---------------- next-state / output logic ----------------
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_cnt_nxt    = r_cnt;
        w_res_nxt    = r_res;
        w_z_nxt      = r_z;
        w_n_nxt      = r_n;
        w_c_nxt      = r_c;
        w_v_nxt      = r_v;
        w_done_nxt   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    unique case (w_op)
                        OP_ADD, OP_SUB: begin
                            w_res_nxt  = w_sum[WIDTH-1:0];
                            w_c_nxt    = w_sum[WIDTH];
                            w_v_nxt    = w_ovf;
                            w_done_nxt = 1'b1;
                        end
                        OP_NOP: begin
                            w_res_nxt  = '0;
                            w_c_nxt    = 1'b0;
                            w_v_nxt    = 1'b0;
                            w_done_nxt = 1'b1;
                        end
                        OP_MUL: begin
                            w_state_nxt  = S_MUL;
                            w_acc_nxt    = '0;
                            w_mcand_nxt  = PW'(bus.in0[MUL_W-1:0]);
                            w_mplier_nxt = bus.in1[MUL_W-1:0];
                            w_cnt_nxt    = '0;
                        end
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                // start is ignored here; res/flags hold until the last step.
                w_acc_nxt    = w_acc_step;
                w_mcand_nxt  = {r_mcand[PW-2:0], 1'b0};
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + CW'(1);
                if (w_last) begin
                    w_res_nxt   = WIDTH'(w_acc_step);
                    w_c_nxt     = 1'b0;
                    w_v_nxt     = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase

        // Z/N always follow the freshly written result.
        if (w_done_nxt) begin
            w_z_nxt = (w_res_nxt == '0);
            w_n_nxt = w_res_nxt[WIDTH-1];
        end
    end

    // ---------------- outputs ----------------
    assign bus.busy = (r_state == S_MUL);
    assign bus.done = r_done;
    assign bus.res  = r_res;
    assign bus.Z    = r_z;
    assign bus.N    = r_n;
    assign bus.C    = r_c;
    assign bus.V    = r_v;

endmodule

// File: tb/tb_aru_seq.sv
// -----------------------------------------------------------------------------
// tb_aru_seq -- directed bench for aru_seq (WIDTH=16, MUL_W=8). Inputs are
// driven on the falling edge and outputs sampled on the falling edge. Every
// accepted op pushes its expected result to a queue; a monitor pops and
// compares on each done pulse, and flags any done with nothing expected.
// -----------------------------------------------------------------------------
module tb_aru_seq;

    localparam int W = 16;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] NOP = 2'b11;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    aru_seq_if #(.WIDTH(W)) bus ();

    aru_seq #(.WIDTH(W), .MUL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model written from the arithmetic definition, not the adder.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        int   sa, sb, r;
        logic [W:0] s;
        sa = $signed(a);
        sb = $signed(b);
        e  = '0;
        case (op)
            ADD: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0];
                e.c   = s[W];
                r     = sa + sb;
                e.v   = (r > 32767) || (r < -32768);
            end
            SUB: begin
                e.res = a - b;
                e.c   = (a >= b);
                r     = sa - sb;
                e.v   = (r > 32767) || (r < -32768);
            end
            MUL: e.res = {8'h00, a[7:0]} * {8'h00, b[7:0]};
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit push);
        bus.start = 1'b1;
        bus.op    = op;
        bus.in0   = a;
        bus.in1   = b;
        if (push) exp_q.push_back(model(op, a, b));
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        check(tag, 32'(bus.done), 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res", 32'(bus.res), 32'(e.res));
                check("Z",   32'(bus.Z),   32'(e.z));
                check("N",   32'(bus.N),   32'(e.n));
                check("C",   32'(bus.C),   32'(e.c));
                check("V",   32'(bus.V),   32'(e.v));
            end
        end
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = ADD;
        bus.in0   = '0;
        bus.in1   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_res",  32'(bus.res),  32'd0);
        check("rst_flags", {28'd0, bus.Z, bus.N, bus.C, bus.V}, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD with signed overflow.
        issue(ADD, 16'h7FFF, 16'h0001, 1'b1);
        @(negedge clk);
        check("add_ovf_done", 32'(bus.done), 32'd1);
        check("add_ovf_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        check("done_single", 32'(bus.done), 32'd0);

        // Carry-out, then borrows/overflow on SUB, back to back.
        issue(ADD, 16'hFFFF, 16'h0001, 1'b1);
        @(negedge clk);
        check("add_carry_done", 32'(bus.done), 32'd1);
        issue(SUB, 16'h0005, 16'h0007, 1'b1);
        @(negedge clk);
        check("sub_borrow_done", 32'(bus.done), 32'd1);
        issue(SUB, 16'h8000, 16'h0001, 1'b1);
        @(negedge clk);
        check("sub_ovf_done", 32'(bus.done), 32'd1);
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b_idle", 32'(bus.done), 32'd0);

        // MUL with operand change after acceptance and an ignored start at T+3.
        issue(MUL, 16'h12FF, 16'h34FF, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("mul_busy_%0d", i), 32'(bus.busy), 32'd1);
            check($sformatf("mul_nodone_%0d", i), 32'(bus.done), 32'd0);
            bus.start = (i == 3);
            if (i == 1) begin
                bus.in0 = 16'hFFFF;
                bus.in1 = 16'hFFFF;
            end
            if (i == 3) begin
                bus.op  = ADD;
                bus.in0 = 16'h0001;
                bus.in1 = 16'h0001;
            end
        end
        @(negedge clk);
        check("mul_done_t9", 32'(bus.done), 32'd1);
        check("mul_busy_t9", 32'(bus.busy), 32'd0);
        check("mul_res_t9",  32'(bus.res),  32'h0000FE01);
        @(negedge clk);
        check("mul_no_extra", 32'(bus.done), 32'd0);

        // Zero product.
        issue(MUL, 16'h0003, 16'h0000, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("mul_zero_done", 20);
        @(negedge clk);

        // Reset in the middle of a MUL: aborted op never completes.
        issue(MUL, 16'h00FF, 16'h00FF, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_res",   32'(bus.res),  32'd0);
        check("abort_flags", {28'd0, bus.Z, bus.N, bus.C, bus.V}, 32'd0);
        check("abort_busy",  32'(bus.busy), 32'd0);
        check("abort_done",  32'(bus.done), 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_idle", 32'(bus.busy), 32'd0);

        issue(ADD, 16'h0002, 16'h0003, 1'b1);
        @(negedge clk);
        check("post_rst_done", 32'(bus.done), 32'd1);
        check("post_rst_res",  32'(bus.res),  32'd5);
        bus.start = 1'b0;
        @(negedge clk);

        // Four single-cycle ops with start held high.
        issue(ADD, 16'h1234, 16'h1111, 1'b1);
        @(negedge clk);
        check("b2b4_done0", 32'(bus.done), 32'd1);
        issue(SUB, 16'h1000, 16'h0001, 1'b1);
        @(negedge clk);
        check("b2b4_done1", 32'(bus.done), 32'd1);
        issue(NOP, 16'hABCD, 16'h1234, 1'b1);
        @(negedge clk);
        check("b2b4_done2", 32'(bus.done), 32'd1);
        check("nop_z", 32'(bus.Z), 32'd1);
        issue(ADD, 16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        check("b2b4_done3", 32'(bus.done), 32'd1);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aru_seq.md
Name: aru_seq

Overview:
- Parametrised, registered successor of the datapath arithmetic unit.
- Performs ADD, SUB, multiply-low and NOP on WIDTH-bit operands, with registered Z/N/C/V flags and a start/done handshake.
- ADD, SUB and NOP complete in one cycle. MUL is an iterative shift-add over MUL_W cycles.
- Sits in the datapath between the register file and the writeback mux, driven by the controller FSM.

Parameters:
- WIDTH, 16, operand/result width (>= 4).
- MUL_W, WIDTH/2, multiplier operand width; uses in0[MUL_W-1:0] and in1[MUL_W-1:0]; constraint 2*MUL_W <= WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 NOP.
- in0  in  WIDTH  operand A (two's complement).
- in1  in  WIDTH  operand B (two's complement).
- busy  out  1  MUL iteration in progress.
- done  out  1  one-cycle pulse: res and flags updated.
- res  out  WIDTH  registered result.
- Z  out  1  res == 0.
- N  out  1  res[WIDTH-1].
- C  out  1  carry-out (ADD/SUB); 0 for MUL/NOP.
- V  out  1  signed overflow (ADD/SUB); 0 for MUL/NOP.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). Sampled at the rising edge.
- Reset values: res=0, Z=N=C=V=0, done=0, busy=0, state=IDLE, iteration counter=0, accumulator=0.
- States: IDLE, MUL.
- Accept: start=1 and state=IDLE in cycle T. op, in0 and in1 are latched at the edge ending T. start while busy=1 is ignored and not queued.
- ADD: {C,res} = in0 + in1 (WIDTH+1-bit sum). V = (a_s == b_s) && (r_s != a_s). res/flags/done=1 visible in cycle T+1. State stays IDLE.
- SUB: {C,res} = in0 + ~in1 + 1. C=1 means no borrow. V = (a_s != b_s) && (r_s != a_s). Same timing as ADD.
- NOP: res=0, Z=1, N=C=V=0, done=1 in cycle T+1.
- MUL:
  - Enter MUL with acc=0, multiplicand = zero-extended in0[MUL_W-1:0], multiplier = in1[MUL_W-1:0], cnt=0.
  - Each MUL cycle: if multiplier LSB=1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++.
  - At the edge completing iteration MUL_W: res = acc (unsigned MUL_W x MUL_W product, zero-extended to WIDTH), Z/N from res, C=V=0, done=1, state -> IDLE.
  - busy=1 in cycles T+1 .. T+MUL_W. done=1 in cycle T+MUL_W+1 (MUL_W=8: T+9).
- done is high for exactly one cycle per accepted op. Back-to-back: start may be asserted in the done cycle (state IDLE); single-cycle ops issued every cycle give done every cycle.
- res and flags hold their value between completions. Outputs do not change while busy=1.
- Z and N are always derived from the new res at completion.
- Reset mid-MUL: all outputs and state return to reset values on that edge; no done is produced for the aborted op.
- Reset has priority over a simultaneous start.
- Operand changes after acceptance have no effect.

Test Plan:
- ADD 0x7FFF + 0x0001, start in T -> cycle T+1: res=0x8000, N=1, V=1, C=0, Z=0, done=1, busy=0.
- ADD 0xFFFF + 0x0001 -> res=0x0000, Z=1, C=1, V=0, N=0. Then SUB 0x0005 - 0x0007 -> res=0xFFFE, N=1, C=0, V=0. SUB 0x8000 - 0x0001 -> res=0x7FFF, V=1, C=1.
- MUL in0=0x12FF, in1=0x34FF, start in T -> busy=1 for T+1..T+8. At T+9: res=0xFE01, N=1, C=V=0, done=1. Also check 0x0003*0x0000 -> res=0, Z=1.
- start with ADD during MUL busy (cycle T+3) -> ignored: single done at T+9, res=0xFE01, no extra done afterwards.
- rst_n=0 at cycle T+4 of a MUL -> next cycle: res=0, all flags 0, busy=0, done never pulses. A following ADD 2+3 gives res=5 at +1 cycle.
- Four back-to-back single-cycle ops (ADD, SUB, NOP, ADD), start held high -> done high four consecutive cycles with the correct res for each; NOP gives res=0, Z=1.
